// File: rtl/xadc_wiz_model.sv
// Behavioural XADC wizard stand-in: alternating VAUX0/VAUX1 conversions with a DRP
// register port (status/result read-only, config 0x40-0x4F and 0x50 read/write).
module xadc_wiz_model #(
   parameter int          CONV_CYCLES = 26,
   parameter int          DRP_LATENCY = 2,
   parameter logic [11:0] TEMP_CODE   = 12'h9A0
) (
   input  logic        dclk_in,
   input  logic        reset_in,
   input  logic [6:0]  daddr_in,
   input  logic        den_in,
   input  logic [15:0] di_in,
   input  logic        dwe_in,
   output logic        busy_out,
   output logic [4:0]  channel_out,
   output logic [15:0] do_out,
   output logic        eoc_out,
   output logic        eos_out,
   output logic        alarm_out,
   output logic        drdy_out,
   input  logic        vp_in,
   input  logic        vn_in,
   input  logic        vauxp0,
   input  logic        vauxn0,
   input  logic        vauxp1,
   input  logic        vauxn1
);

   localparam int             CW        = $clog2(CONV_CYCLES + 1);
   localparam logic [CW-1:0]  CONV_LAST = CW'(CONV_CYCLES);
   localparam logic [15:0]    TEMP_REG  = {TEMP_CODE, 4'b0000};
   localparam logic [7:0]     LAT_INIT  = (DRP_LATENCY > 1) ? 8'(DRP_LATENCY - 2) : 8'd0;

   typedef enum logic {ST_GAP, ST_CONV} conv_state_t;

   conv_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic          sample_q, sample_d;
   logic          eoc_q, eoc_d;
   logic          eos_q, eos_d;
   logic [4:0]    channel_q, channel_d;
   logic [15:0]   res0_q, res0_d;
   logic [15:0]   res1_q, res1_d;
   logic [15:0]   cfg_q [16];
   logic [15:0]   cfg_d [16];
   logic [15:0]   cfg50_q, cfg50_d;
   logic          alarm_q, alarm_d;
   logic          pend_q, pend_d;
   logic [7:0]    lat_q, lat_d;
   logic [6:0]    addr_q, addr_d;
   logic          we_q, we_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   snap_q, snap_d;
   logic [15:0]   do_q, do_d;
   logic          drdy_q, drdy_d;

   logic [15:0]   rd_val;
   logic          fin;
   logic [6:0]    fin_addr;
   logic          fin_we;
   logic [15:0]   fin_data;
   logic [15:0]   fin_snap;
   logic          unused_pins;

   assign unused_pins = vp_in ^ vn_in;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      sample_d  = sample_q;
      eoc_d     = 1'b0;
      eos_d     = 1'b0;
      channel_d = channel_q;
      res0_d    = res0_q;
      res1_d    = res1_q;
      cfg_d     = cfg_q;
      cfg50_d   = cfg50_q;
      pend_d    = pend_q;
      lat_d     = lat_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      snap_d    = snap_q;
      do_d      = do_q;
      drdy_d    = 1'b0;
      fin       = 1'b0;
      fin_addr  = addr_q;
      fin_we    = we_q;
      fin_data  = wdata_q;
      fin_snap  = snap_q;
      alarm_d   = (TEMP_REG > cfg50_q);

      // The one-cycle gap state doubles as the end-of-conversion cycle.
      case (state_q)
         ST_GAP: begin
            state_d  = ST_CONV;
            cnt_d    = CW'(1);
            sample_d = sel_q ? (vauxp1 & ~vauxn1) : (vauxp0 & ~vauxn0);
         end
         ST_CONV: begin
            if (cnt_q == CONV_LAST) begin
               state_d   = ST_GAP;
               eoc_d     = 1'b1;
               eos_d     = sel_q;
               channel_d = {4'b1000, sel_q};
               sel_d     = ~sel_q;
               if (sel_q) res1_d = {{12{sample_q}}, 4'b0000};
               else       res0_d = {{12{sample_q}}, 4'b0000};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_GAP;
      endcase

      case (daddr_in)
         7'h00:   rd_val = TEMP_REG;
         7'h10:   rd_val = res0_q;
         7'h11:   rd_val = res1_q;
         7'h50:   rd_val = cfg50_q;
         default: rd_val = (daddr_in[6:4] == 3'b100) ? cfg_q[daddr_in[3:0]] : 16'h0000;
      endcase

      // Reads snapshot the register at acceptance, so a same-cycle result update is not seen.
      if (pend_q) begin
         if (lat_q == 8'd0) begin
            pend_d = 1'b0;
            fin    = 1'b1;
         end else begin
            lat_d = lat_q - 8'd1;
         end
      end else if (den_in) begin
         addr_d  = daddr_in;
         we_d    = dwe_in;
         wdata_d = di_in;
         snap_d  = rd_val;
         if (DRP_LATENCY <= 1) begin
            fin      = 1'b1;
            fin_addr = daddr_in;
            fin_we   = dwe_in;
            fin_data = di_in;
            fin_snap = rd_val;
         end else begin
            pend_d = 1'b1;
            lat_d  = LAT_INIT;
         end
      end

      if (fin) begin
         drdy_d = 1'b1;
         if (fin_we) begin
            if (fin_addr == 7'h50)             cfg50_d = fin_data;
            else if (fin_addr[6:4] == 3'b100)  cfg_d[fin_addr[3:0]] = fin_data;
         end else begin
            do_d = fin_snap;
         end
      end
   end

   always_ff @(posedge dclk_in) begin
      if (reset_in) begin
         state_q   <= ST_GAP;
         cnt_q     <= '0;
         sel_q     <= 1'b0;
         sample_q  <= 1'b0;
         eoc_q     <= 1'b0;
         eos_q     <= 1'b0;
         channel_q <= 5'h00;
         res0_q    <= 16'h0000;
         res1_q    <= 16'h0000;
         cfg_q     <= '{default: 16'h0000};
         cfg50_q   <= 16'hFFFF;
         alarm_q   <= 1'b0;
         pend_q    <= 1'b0;
         lat_q     <= 8'd0;
         addr_q    <= 7'h00;
         we_q      <= 1'b0;
         wdata_q   <= 16'h0000;
         snap_q    <= 16'h0000;
         do_q      <= 16'h0000;
         drdy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         sample_q  <= sample_d;
         eoc_q     <= eoc_d;
         eos_q     <= eos_d;
         channel_q <= channel_d;
         res0_q    <= res0_d;
         res1_q    <= res1_d;
         cfg_q     <= cfg_d;
         cfg50_q   <= cfg50_d;
         alarm_q   <= alarm_d;
         pend_q    <= pend_d;
         lat_q     <= lat_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         snap_q    <= snap_d;
         do_q      <= do_d;
         drdy_q    <= drdy_d;
      end
   end

   assign busy_out    = (state_q == ST_CONV);
   assign channel_out = channel_q;
   assign do_out      = do_q;
   assign eoc_out     = eoc_q;
   assign eos_out     = eos_q;
   assign alarm_out   = alarm_q;
   assign drdy_out    = drdy_q;

endmodule

// File: tb/tb_xadc_wiz_model.sv
// Self-checking bench for xadc_wiz_model: conversion timing/channels from cycle arithmetic,
// DRP behaviour against a register-map model, alarm threshold and mid-operation reset.
module tb_xadc_wiz_model;

   localparam int PERIOD = 27;

   logic        dclk_in = 1'b0;
   logic        reset_in = 1'b1;
   logic [6:0]  daddr_in = '0;
   logic        den_in = 1'b0;
   logic [15:0] di_in = '0;
   logic        dwe_in = 1'b0;
   logic        busy_out, eoc_out, eos_out, alarm_out, drdy_out;
   logic [4:0]  channel_out;
   logic [15:0] do_out;
   logic        vp_in = 1'b0, vn_in = 1'b0;
   logic        vauxp0 = 1'b0, vauxn0 = 1'b0, vauxp1 = 1'b0, vauxn1 = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          edges = 0;
   logic [15:0] cfg_m [16];
   logic [15:0] cfg50_m;

   xadc_wiz_model dut (
      .dclk_in(dclk_in), .reset_in(reset_in), .daddr_in(daddr_in), .den_in(den_in),
      .di_in(di_in), .dwe_in(dwe_in), .busy_out(busy_out), .channel_out(channel_out),
      .do_out(do_out), .eoc_out(eoc_out), .eos_out(eos_out), .alarm_out(alarm_out),
      .drdy_out(drdy_out), .vp_in(vp_in), .vn_in(vn_in), .vauxp0(vauxp0), .vauxn0(vauxn0),
      .vauxp1(vauxp1), .vauxn1(vauxn1)
   );

   always #5 dclk_in = ~dclk_in;

   // Clock edges since reset was last seen released; drives the timing model.
   always @(posedge dclk_in) begin
      if (reset_in) edges <= 0;
      else          edges <= edges + 1;
   end

   function automatic logic [15:0] code_of(input logic p, input logic n);
      return (p && !n) ? 16'hFFF0 : 16'h0000;
   endfunction

   function automatic logic [15:0] exp_reg(input logic [6:0] a, input int e);
      if (a == 7'h00) return 16'h9A00;
      if (a == 7'h10) return (e >= PERIOD) ? code_of(vauxp0, vauxn0) : 16'h0000;
      if (a == 7'h11) return (e >= 2 * PERIOD) ? code_of(vauxp1, vauxn1) : 16'h0000;
      if (a == 7'h50) return cfg50_m;
      if (a >= 7'h40 && a <= 7'h4F) return cfg_m[a - 7'h40];
      return 16'h0000;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) cfg_m[i] = 16'h0000;
      cfg50_m = 16'hFFFF;
   endtask

   task automatic do_reset();
      @(negedge dclk_in);
      reset_in = 1'b1;
      repeat (2) @(negedge dclk_in);
      reset_in = 1'b0;
      model_reset();
   endtask

   // Drives one DRP transaction; returns drdy latency (0 when drdy_out never pulses), read data and acceptance timestamp.
   task automatic drp_xact(input logic [6:0] a, input logic w, input logic [15:0] d,
                           output int lat, output logic [15:0] rd, output int at_edges);
      @(negedge dclk_in);
      daddr_in = a; dwe_in = w; di_in = d; den_in = 1'b1;
      at_edges = edges;
      lat = 0;
      rd = 16'hxxxx;
      for (int i = 1; i <= 8; i++) begin
         @(negedge dclk_in);
         if (i == 1) begin den_in = 1'b0; dwe_in = 1'b0; end
         if (drdy_out) begin
            lat = i;
            rd = do_out;
            break;
         end
      end
      if (w && lat != 0) begin
         if (a == 7'h50) cfg50_m = d;
         else if (a >= 7'h40 && a <= 7'h4F) cfg_m[a - 7'h40] = d;
      end
   endtask

   task automatic test_reset();
      reset_in = 1'b1;
      repeat (2) @(negedge dclk_in);
      n_checks++;
      if ({busy_out, eoc_out, eos_out, drdy_out, alarm_out} !== 5'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b expected 00000", {busy_out, eoc_out, eos_out, drdy_out, alarm_out});
      end
      n_checks++;
      if (channel_out !== 5'h00 || do_out !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL reset_data: got ch=%h do=%h expected ch=00 do=0000", channel_out, do_out);
      end
   endtask

   task automatic test_conversion(input int iter);
      int lat, at;
      logic [15:0] rd;
      int n, k;
      logic e_busy, e_eoc, e_eos;
      logic [4:0] e_ch;
      @(negedge dclk_in);
      reset_in = 1'b1;
      if (iter == 0) {vauxp0, vauxn0, vauxp1, vauxn1} = 4'b1000;
      else           {vauxp0, vauxn0, vauxp1, vauxn1} = 4'($urandom_range(0, 15));
      do_reset();
      for (int c = 1; c <= 2 * PERIOD + 3; c++) begin
         @(negedge dclk_in);
         n = edges;
         k = n / PERIOD;
         e_eoc  = (n >= PERIOD) && (n % PERIOD == 0);
         e_busy = (n >= 1) && (n % PERIOD != 0);
         e_eos  = e_eoc && (((k - 1) % 2) == 1);
         e_ch   = (k == 0) ? 5'h00 : ((((k - 1) % 2) == 1) ? 5'h11 : 5'h10);
         n_checks++;
         if ({busy_out, eoc_out, eos_out} !== {e_busy, e_eoc, e_eos} || channel_out !== e_ch) begin
            n_fail++;
            $display("[TB] FAIL conv_timing n=%0d: got busy/eoc/eos=%b ch=%h expected %b ch=%h",
                     n, {busy_out, eoc_out, eos_out}, channel_out, {e_busy, e_eoc, e_eos}, e_ch);
         end
      end
      for (int a = 16; a <= 17; a++) begin
         drp_xact(7'(a), 1'b0, 16'h0, lat, rd, at);
         n_checks++;
         if (lat != 2 || rd !== exp_reg(7'(a), at)) begin
            n_fail++;
            $display("[TB] FAIL result_read a=%h: got lat=%0d do=%h expected lat=2 do=%h", a, lat, rd, exp_reg(7'(a), at));
         end
      end
   endtask

   task automatic test_drp_read();
      int lat, at;
      logic [15:0] rd;
      logic [6:0] addrs [4];
      addrs[0] = 7'h00; addrs[1] = 7'h20; addrs[2] = 7'h03;
      addrs[3] = 7'h60 | 7'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
         drp_xact(addrs[i], 1'b0, 16'h0, lat, rd, at);
         n_checks++;
         if (lat != 2 || rd !== exp_reg(addrs[i], at)) begin
            n_fail++;
            $display("[TB] FAIL drp_read a=%h: got lat=%0d do=%h expected lat=2 do=%h", addrs[i], lat, rd, exp_reg(addrs[i], at));
         end
      end
   endtask

   task automatic test_drp_write();
      int lat, at;
      logic [15:0] rd, prev;
      logic [6:0] a;
      logic [15:0] d;
      for (int i = 0; i < 6; i++) begin
         a = (i == 0) ? 7'h42 : ((i == 5) ? 7'h10 : 7'h40 | 7'($urandom_range(0, 15)));
         d = (i == 0) ? 16'h1234 : ((i == 5) ? 16'hBEEF : 16'($urandom));
         prev = do_out;
         drp_xact(a, 1'b1, d, lat, rd, at);
         n_checks++;
         if (lat != 2 || rd !== prev) begin
            n_fail++;
            $display("[TB] FAIL drp_write a=%h: got lat=%0d do=%h expected lat=2 do=%h", a, lat, rd, prev);
         end
         drp_xact(a, 1'b0, 16'h0, lat, rd, at);
         n_checks++;
         if (lat != 2 || rd !== exp_reg(a, at)) begin
            n_fail++;
            $display("[TB] FAIL write_readback a=%h: got lat=%0d do=%h expected do=%h", a, lat, rd, exp_reg(a, at));
         end
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0, lat = 0;
      logic [15:0] rd = 16'h0;
      @(negedge dclk_in);
      daddr_in = 7'h00; dwe_in = 1'b0; den_in = 1'b1;
      @(negedge dclk_in);
      if (drdy_out) pulses++;
      daddr_in = 7'h42;
      for (int i = 2; i <= 8; i++) begin
         @(negedge dclk_in);
         if (i == 2) den_in = 1'b0;
         if (drdy_out) begin
            pulses++;
            if (lat == 0) begin lat = i; rd = do_out; end
         end
      end
      n_checks++;
      if (pulses != 1 || lat != 2 || rd !== 16'h9A00) begin
         n_fail++;
         $display("[TB] FAIL back_to_back: got pulses=%0d lat=%0d do=%h expected 1 2 9a00", pulses, lat, rd);
      end
   endtask

   task automatic test_alarm();
      int lat, at;
      logic [15:0] rd, thr;
      for (int i = 0; i < 6; i++) begin
         thr = (i == 0) ? 16'h8000 : ((i == 5) ? 16'hFFFF : 16'($urandom));
         drp_xact(7'h50, 1'b1, thr, lat, rd, at);
         @(negedge dclk_in);
         n_checks++;
         if (lat != 2 || alarm_out !== (16'h9A00 > thr)) begin
            n_fail++;
            $display("[TB] FAIL alarm thr=%h: got lat=%0d alarm=%b expected %b", thr, lat, alarm_out, 16'h9A00 > thr);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat, at, guard;
      logic [15:0] rd;
      logic [6:0] a;
      guard = 0;
      while ((edges % PERIOD) != 10 && guard < 100) begin
         @(negedge dclk_in);
         guard++;
      end
      daddr_in = 7'h10; dwe_in = 1'b0; den_in = 1'b1;
      @(negedge dclk_in);
      den_in = 1'b0;
      reset_in = 1'b1;
      @(negedge dclk_in);
      reset_in = 1'b0;
      model_reset();
      n_checks++;
      if ({busy_out, eoc_out, eos_out, drdy_out, alarm_out} !== 5'b0 || do_out !== 16'h0 || channel_out !== 5'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_outputs: got flags=%b do=%h ch=%h expected 0", {busy_out, eoc_out, eos_out, drdy_out, alarm_out}, do_out, channel_out);
      end
      guard = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge dclk_in);
         if (drdy_out) guard++;
      end
      n_checks++;
      if (guard != 0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_drdy: got %0d stray pulses expected 0", guard);
      end
      for (int i = 0; i < 4; i++) begin
         a = (i == 0) ? 7'h10 : ((i == 1) ? 7'h11 : ((i == 2) ? 7'h42 : 7'h50));
         drp_xact(a, 1'b0, 16'h0, lat, rd, at);
         n_checks++;
         if (lat != 2 || rd !== exp_reg(a, at)) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_reg a=%h: got lat=%0d do=%h expected %h", a, lat, rd, exp_reg(a, at));
         end
      end
      guard = 0;
      while (edges < PERIOD && guard < 100) begin
         @(negedge dclk_in);
         guard++;
      end
      n_checks++;
      if (edges != PERIOD || eoc_out !== 1'b1 || channel_out !== 5'h10 || eos_out !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL restart_vaux0: got n=%0d eoc=%b ch=%h eos=%b expected n=%0d eoc=1 ch=10 eos=0",
                  edges, eoc_out, channel_out, eos_out, PERIOD);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      for (int it = 0; it < 3; it++) test_conversion(it);
      test_drp_read();
      test_drp_write();
      test_back_to_back();
      test_alarm();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
